// File: rtl/buffer_controller_pkg.sv
// Shared types and widths for the buffer controller slice.
package buffer_controller_pkg;

  localparam int unsigned PTR_W = 4;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2,
    ST_FLUSH   = 2'd3
  } buf_state_e;

endpackage

// File: rtl/buffer_controller_ptr_wrap.sv
// Next-pointer calculation: advance by STEP when adv is set, wrapping modulo MOD.
module ptr_wrap
  import buffer_controller_pkg::*;
#(
  parameter int unsigned STEP = 1,
  parameter int unsigned MOD  = 16
) (
  input  logic [PTR_W-1:0] ptr,
  input  logic             adv,
  output logic [PTR_W-1:0] ptr_next
);

  localparam int unsigned SUM_W = PTR_W + 1;
  localparam logic [SUM_W-1:0] STEP_C = SUM_W'(STEP);
  localparam logic [SUM_W-1:0] MOD_C  = SUM_W'(MOD);

  logic [SUM_W-1:0] sum;

  // STEP <= MOD and ptr < MOD, so one conditional subtract is a full modulo.
  always_comb begin
    sum = {1'b0, ptr} + STEP_C;
    if (sum >= MOD_C) begin
      sum = sum - MOD_C;
    end
    ptr_next = adv ? sum[PTR_W-1:0] : ptr;
  end

endmodule

// File: rtl/buffer_controller.sv
// Multi-entry push/pop controller: pointers, occupancy, FSM and datapath strobes.
module buffer_controller
  import buffer_controller_pkg::*;
#(
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned PAR_WRITE = 3,
  parameter int unsigned PAR_READ  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic             wen,
  output logic [PTR_W-1:0] waddr,
  output logic             ren,
  output logic [PTR_W-1:0] raddr,
  output logic             dout_valid,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] ENTRIES_C = CNT_W'(ENTRIES);
  localparam logic [CNT_W-1:0] PW_C      = CNT_W'(PAR_WRITE);
  localparam logic [CNT_W-1:0] PR_C      = CNT_W'(PAR_READ);

  buf_state_e       state_q, state_d;
  logic [PTR_W-1:0] waddr_q, waddr_d, waddr_nxt;
  logic [PTR_W-1:0] raddr_q, raddr_d, raddr_nxt;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dout_valid_q, dout_valid_d;
  logic             push, pop, blocked;

  assign blocked  = flush | (state_q == ST_FLUSH);
  assign wr_ready = ((ENTRIES_C - count_q) >= PW_C) & ~blocked;
  assign rd_valid = (count_q >= PR_C) & ~blocked;
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;

  ptr_wrap #(.STEP(PAR_WRITE), .MOD(ENTRIES)) u_wptr (
    .ptr      (waddr_q),
    .adv      (push),
    .ptr_next (waddr_nxt)
  );

  ptr_wrap #(.STEP(PAR_READ), .MOD(ENTRIES)) u_rptr (
    .ptr      (raddr_q),
    .adv      (pop),
    .ptr_next (raddr_nxt)
  );

  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    raddr_d      = raddr_q;
    count_d      = count_q;
    dout_valid_d = 1'b0;
    if (flush) begin
      state_d = ST_FLUSH;
      waddr_d = '0;
      raddr_d = '0;
      count_d = '0;
    end else begin
      // push/pop are already gated by the ready/valid limits, so count stays in 0..ENTRIES.
      waddr_d      = waddr_nxt;
      raddr_d      = raddr_nxt;
      count_d      = count_q + (push ? PW_C : '0) - (pop ? PR_C : '0);
      dout_valid_d = pop;
      if (count_d == '0) begin
        state_d = ST_EMPTY;
      end else if (count_d == ENTRIES_C) begin
        state_d = ST_FULL;
      end else begin
        state_d = ST_PARTIAL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      waddr_q      <= '0;
      raddr_q      <= '0;
      count_q      <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      raddr_q      <= raddr_d;
      count_q      <= count_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign wen        = push;
  assign ren        = pop;
  assign waddr      = waddr_q;
  assign raddr      = raddr_q;
  assign count      = count_q;
  assign dout_valid = dout_valid_q;
  assign full       = (count_q == ENTRIES_C);
  assign empty      = (count_q == '0);

endmodule

// File: tb/tb_buffer_controller.sv
// Randomized and directed bench for buffer_controller against an integer occupancy model.
module tb_buffer_controller;
  import buffer_controller_pkg::*;

  localparam int E  = 16;
  localparam int PW = 3;
  localparam int PR = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             wr_valid = 1'b0;
  logic             rd_ready = 1'b0;
  logic             wr_ready, rd_valid, wen, ren, dout_valid, full, empty;
  logic [PTR_W-1:0] waddr, raddr;
  logic [CNT_W-1:0] count;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: plain integers for occupancy and pointers.
  int m_cnt, m_wa, m_ra;
  bit m_flush, m_dv;

  buffer_controller #(.ENTRIES(E), .PAR_WRITE(PW), .PAR_READ(PR)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .wen        (wen),
    .waddr      (waddr),
    .ren        (ren),
    .raddr      (raddr),
    .dout_valid (dout_valid),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wa = 0; m_ra = 0; m_flush = 0; m_dv = 0;
  endtask

  // Drive one cycle's inputs, check every output against the model, then advance the model.
  task automatic step(input bit wv, input bit rr, input bit fl);
    bit e_wr, e_rd, e_push, e_pop;
    @(negedge clk);
    wr_valid = wv; rd_ready = rr; flush = fl;
    #1;
    e_wr   = (E - m_cnt >= PW) && !fl && !m_flush;
    e_rd   = (m_cnt >= PR) && !fl && !m_flush;
    e_push = wv && e_wr;
    e_pop  = rr && e_rd;
    check("wr_ready",   32'(wr_ready),   32'(e_wr));
    check("rd_valid",   32'(rd_valid),   32'(e_rd));
    check("wen",        32'(wen),        32'(e_push));
    check("ren",        32'(ren),        32'(e_pop));
    check("waddr",      32'(waddr),      32'(m_wa));
    check("raddr",      32'(raddr),      32'(m_ra));
    check("count",      32'(count),      32'(m_cnt));
    check("full",       32'(full),       32'(m_cnt == E));
    check("empty",      32'(empty),      32'(m_cnt == 0));
    check("dout_valid", 32'(dout_valid), 32'(m_dv));
    if (fl) begin
      m_cnt = 0; m_wa = 0; m_ra = 0; m_flush = 1; m_dv = 0;
    end else begin
      m_flush = 0;
      if (e_push) begin m_wa = (m_wa + PW) % E; m_cnt += PW; end
      if (e_pop)  begin m_ra = (m_ra + PR) % E; m_cnt -= PR; end
      m_dv = e_pop;
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    #1;
    check("rst_count",    32'(count),      0);
    check("rst_empty",    32'(empty),      1);
    check("rst_full",     32'(full),       0);
    check("rst_wr_ready", 32'(wr_ready),   1);
    check("rst_rd_valid", 32'(rd_valid),   0);
    check("rst_dv",       32'(dout_valid), 0);
    rst = 1'b0;

    // Five pushes fill to 15; no room for another push of 3.
    repeat (5) step(1, 0, 0);
    step(0, 0, 0);
    check("r43_count",    32'(count),    15);
    check("r43_waddr",    32'(waddr),    15);
    check("r43_wr_ready", 32'(wr_ready), 0);
    check("r43_rd_valid", 32'(rd_valid), 1);
    check("r43_full",     32'(full),     0);

    step(0, 1, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    check("r44_raddr",    32'(raddr),    2);
    check("r44_waddr",    32'(waddr),    2);
    check("r44_count",    32'(count),    16);
    check("r44_full",     32'(full),     1);
    check("r44_wr_ready", 32'(wr_ready), 0);

    // Simultaneous push and pop from count=4.
    step(0, 0, 1);
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    check("r45_count", 32'(count),      5);
    check("r45_waddr", 32'(waddr),      9);
    check("r45_raddr", 32'(raddr),      4);
    check("r45_dv1",   32'(dout_valid), 1);
    step(0, 0, 0);
    check("r45_dv2",   32'(dout_valid), 0);

    // Pop request with a single entry is ignored.
    step(0, 0, 1);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    check("r46_rd_valid", 32'(rd_valid), 0);
    check("r46_ren",      32'(ren),      0);
    step(0, 0, 0);
    check("r46_raddr", 32'(raddr),      2);
    check("r46_count", 32'(count),      1);
    check("r46_dv",    32'(dout_valid), 0);

    // Flush beats a simultaneous push and pop at count=10.
    step(0, 0, 1);
    step(0, 0, 0);
    repeat (4) step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    check("r47_count10", 32'(count), 10);
    step(1, 1, 1);
    check("r47_wen", 32'(wen), 0);
    check("r47_ren", 32'(ren), 0);
    step(0, 0, 0);
    check("r47_count", 32'(count),      0);
    check("r47_waddr", 32'(waddr),      0);
    check("r47_raddr", 32'(raddr),      0);
    check("r47_dv",    32'(dout_valid), 0);
    check("r47_flush_wr_ready", 32'(wr_ready), 0);
    step(0, 0, 0);
    check("r47_empty_wr_ready", 32'(wr_ready), 1);

    // Reset pulsed between edges while a pop is in progress.
    step(1, 0, 0);
    step(0, 1, 0);
    @(negedge clk);
    rd_ready = 1'b1; wr_valid = 1'b0; flush = 1'b0;
    #1;
    check("r48_pre_dv", 32'(dout_valid), 32'(m_dv));
    #1 rst = 1'b1;
    #1;
    check("r48_count",    32'(count),      0);
    check("r48_raddr",    32'(raddr),      0);
    check("r48_waddr",    32'(waddr),      0);
    check("r48_dv",       32'(dout_valid), 0);
    check("r48_empty",    32'(empty),      1);
    check("r48_wr_ready", 32'(wr_ready),   1);
    check("r48_rd_valid", 32'(rd_valid),   0);
    check("r48_ren",      32'(ren),        0);
    model_reset();
    #1 rst = 1'b0;
    step(0, 0, 0);
    check("r48_post_dv", 32'(dout_valid), 0);

    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           $urandom_range(0, 19) == 0);
    end
    step(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
